// File: rtl/bin_a_bcd_seq_if.sv
// Handshake and result bundle for the sequential binary-to-BCD converter.
// The master drives start/bin_in. The slave (converter) returns status and the four BCD digits.
interface bin_a_bcd_seq_if #(
    parameter int N = 10
);
    logic         start;
    logic [N-1:0] bin_in;
    logic         busy;
    logic         done;
    logic [3:0]   bcd_unidad;
    logic [3:0]   bcd_decena;
    logic [3:0]   bcd_centena;
    logic [3:0]   bcd_mil;

    modport master (
        output start, bin_in,
        input  busy, done, bcd_unidad, bcd_decena, bcd_centena, bcd_mil
    );

    modport slave (
        input  start, bin_in,
        output busy, done, bcd_unidad, bcd_decena, bcd_centena, bcd_mil
    );
endinterface

// File: rtl/bin_a_bcd_seq.sv
// Sequential double-dabble binary-to-BCD converter: one shift per cycle, N shifts per result.
// Optional macro AUTO_RESTART_EN: in IDLE, start a new conversion every cycle and ignore start.
module bin_a_bcd_seq #(
    parameter int N      = 10,
    parameter int DIGITS = 4
) (
    input  logic           clk,
    input  logic           rst,
    bin_a_bcd_seq_if.slave bus
);
    localparam int SCR_W = 4 * DIGITS;
    localparam int CNT_W = $clog2(N + 1);

    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

    state_t           state, state_next;
    logic [N-1:0]     binreg;
    logic [SCR_W-1:0] scratch, adj, scratch_next;
    logic [SCR_W-1:0] bcd;
    logic [CNT_W-1:0] cnt;
    logic             go, last;

    // Each nibble wraps modulo 16. Legal inputs never push a nibble past 12.
    function automatic logic [SCR_W-1:0] add3(input logic [SCR_W-1:0] s);
        logic [SCR_W-1:0] r;
        r = s;
        for (int i = 0; i < DIGITS; i++) begin
            if (s[4*i +: 4] >= 4'd5)
                r[4*i +: 4] = s[4*i +: 4] + 4'd3;
        end
        return r;
    endfunction

`ifdef AUTO_RESTART_EN
    assign go = 1'b1;
`else
    assign go = bus.start;
`endif

    assign adj          = add3(scratch);
    assign scratch_next = {adj[SCR_W-2:0], binreg[N-1]};
    assign last         = (cnt == CNT_W'(1));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (go) state_next = SHIFT;
            SHIFT:   if (last) state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // The outputs load only on the final shift, so the displays never show partial digits.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            binreg  <= '0;
            scratch <= '0;
            cnt     <= '0;
            bcd     <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (go) begin
                        binreg  <= bus.bin_in;
                        scratch <= '0;
                        cnt     <= CNT_W'(N);
                    end
                end
                SHIFT: begin
                    binreg  <= binreg << 1;
                    scratch <= scratch_next;
                    cnt     <= cnt - 1'b1;
                    if (last) bcd <= scratch_next;
                end
                default: ;
            endcase
        end
    end

    assign bus.busy        = (state != IDLE);
    assign bus.done        = (state == DONE);
    assign bus.bcd_unidad  = bcd[3:0];
    assign bus.bcd_decena  = bcd[7:4];
    assign bus.bcd_centena = bcd[11:8];
    assign bus.bcd_mil     = bcd[15:12];
endmodule

// File: tb/tb_bin_a_bcd_seq.sv
// Self-checking bench for bin_a_bcd_seq: directed cases plus random traffic against a behavioural model.
// The model also covers the AUTO_RESTART_EN build.
module tb_bin_a_bcd_seq;
    localparam int N = 10;

`ifdef AUTO_RESTART_EN
    localparam bit AUTO = 1'b1;
`else
    localparam bit AUTO = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    bin_a_bcd_seq_if #(.N(N)) bus ();

    bin_a_bcd_seq #(.N(N), .DIGITS(4)) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    int total = 0;
    int bad   = 0;
    bit chk_on = 1'b0;

    // Model state: cycles of busy remaining, the captured value and the displayed value.
    int m_cnt  = 0;
    int m_cap  = 0;
    int m_disp = 0;

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s got=%0d want=%0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int disp();
        return int'(bus.bcd_mil) * 1000 + int'(bus.bcd_centena) * 100 +
               int'(bus.bcd_decena) * 10 + int'(bus.bcd_unidad);
    endfunction

    // Each accepted value keeps the converter busy for N+1 cycles. The result appears in the last of them.
    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            m_cnt  <= 0;
            m_cap  <= 0;
            m_disp <= 0;
        end else if (m_cnt == 0) begin
            if (AUTO || bus.start) begin
                m_cap <= int'(bus.bin_in);
                m_cnt <= N + 1;
            end
        end else begin
            m_cnt <= m_cnt - 1;
            if (m_cnt == 2) m_disp <= m_cap;
        end
    end

    always @(negedge clk) begin
        if (chk_on) begin
            check("busy",    int'(bus.busy), int'(m_cnt != 0));
            check("done",    int'(bus.done), int'(m_cnt == 1));
            check("unidad",  int'(bus.bcd_unidad),  m_disp % 10);
            check("decena",  int'(bus.bcd_decena),  (m_disp / 10) % 10);
            check("centena", int'(bus.bcd_centena), (m_disp / 100) % 10);
            check("mil",     int'(bus.bcd_mil),     (m_disp / 1000) % 10);
        end
    end

`ifndef AUTO_RESTART_EN
    task automatic convert(input int v, input int want, input string tag);
        int nbusy, dcyc;
        nbusy = 0;
        dcyc  = -1;
        @(negedge clk); bus.start = 1'b1; bus.bin_in = N'(v);
        @(negedge clk); bus.start = 1'b0; bus.bin_in = N'($urandom_range(0, 1023));
        for (int k = 0; k < 40; k++) begin
            if (bus.busy) nbusy++;
            if (bus.done) begin
                dcyc = k;
                break;
            end
            @(negedge clk);
        end
        check({tag, "_latency"}, dcyc, N);
        check({tag, "_busycycles"}, nbusy, N + 1);
        check({tag, "_value"}, disp(), want);
        @(negedge clk);
        check({tag, "_idle"}, int'(bus.busy), 0);
    endtask

    task automatic start_while_busy();
        int nd, val;
        nd  = 0;
        val = -1;
        @(negedge clk); bus.start = 1'b1; bus.bin_in = N'(456);
        @(negedge clk); bus.start = 1'b0;
        for (int k = 0; k < 30; k++) begin
            if (bus.done) begin
                nd++;
                val = disp();
            end
            if (k == 4) begin
                bus.start  = 1'b1;
                bus.bin_in = N'(77);
            end else begin
                bus.start = 1'b0;
            end
            @(negedge clk);
        end
        check("busy_start_dones", nd, 1);
        check("busy_start_value", val, 456);
    endtask

    task automatic back_to_back();
        int d1, d2, v1, v2, nd;
        d1 = -1; d2 = -1; v1 = -1; v2 = -1; nd = 0;
        @(negedge clk); bus.start = 1'b1; bus.bin_in = N'(321);
        @(negedge clk); bus.bin_in = N'(654);
        for (int k = 0; k < 40; k++) begin
            if (bus.done) begin
                nd++;
                if (d1 < 0) begin
                    d1 = k; v1 = disp();
                end else if (d2 < 0) begin
                    d2 = k; v2 = disp();
                end
            end
            if (k == 12) bus.start = 1'b0;
            @(negedge clk);
        end
        check("b2b_dones", nd, 2);
        check("b2b_first_at", d1, N);
        check("b2b_spacing", d2 - d1, N + 2);
        check("b2b_first", v1, 321);
        check("b2b_second", v2, 654);
    endtask
`else
    task automatic done_period();
        int d1, d2;
        d1 = -1; d2 = -1;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (bus.done) begin
                if (d1 < 0) d1 = k;
                else if (d2 < 0) d2 = k;
            end
        end
        check("auto_period", d2 - d1, N + 2);
    endtask
`endif

    initial begin
        bus.start  = 1'b0;
        bus.bin_in = '0;
        rst        = 1'b0;
        repeat (3) @(negedge clk);
        check("reset_busy", int'(bus.busy), 0);
        check("reset_done", int'(bus.done), 0);
        check("reset_value", disp(), 0);
        chk_on = 1'b1;
        rst    = 1'b1;

`ifndef AUTO_RESTART_EN
        convert(1023, 1023, "max");
        check("max_mil", int'(bus.bcd_mil), 1);
        check("max_unidad", int'(bus.bcd_unidad), 3);
        convert(999, 999, "n999");
        convert(500, 500, "n500");
        convert(0, 0, "zero");
        convert(1000, 1000, "n1000");
        start_while_busy();
        back_to_back();
`else
        bus.bin_in = N'(42);
        repeat (26) @(negedge clk);
        check("auto_42", disp(), 42);
        done_period();
        bus.bin_in = N'(1000);
        repeat (26) @(negedge clk);
        check("auto_1000", disp(), 1000);
`endif

        // Abort a conversion part way through its shifts.
        @(negedge clk); bus.start = 1'b1; bus.bin_in = N'(1023);
        @(negedge clk); bus.start = 1'b0;
        repeat (3) @(negedge clk);
        #2 rst = 1'b0;
        #1;
        check("abort_busy", int'(bus.busy), 0);
        check("abort_done", int'(bus.done), 0);
        check("abort_value", disp(), 0);
        @(negedge clk);
        rst = 1'b1;
`ifndef AUTO_RESTART_EN
        repeat (6) @(negedge clk);
        check("post_abort_value", disp(), 0);
        check("post_abort_busy", int'(bus.busy), 0);
`endif

        for (int k = 0; k < 500; k++) begin
            @(negedge clk);
            bus.start = ($urandom_range(0, 3) == 0);
            if ($urandom_range(0, 2) == 0) bus.bin_in = N'($urandom_range(0, 1023));
        end
        bus.start = 1'b0;
        repeat (15) @(negedge clk);

        chk_on = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout want=finish");
        $fatal(1, "watchdog");
    end
endmodule
